// File: rtl/branch_ctrl.sv
// Branch resolution controller: captures a branch request, resolves it through an
// external shared unsigned comparator and holds the outcome until the consumer takes it.
// Optional statistics counters are enabled with the BRANCH_CTRL_STATS_EN macro.
module branch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic [31:0] cmp_a,
    output logic [31:0] cmp_b,
    input  logic        cmp_eq,
    input  logic        cmp_lt,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        taken,
    output logic [31:0] next_pc,
    output logic        illegal
`ifdef BRANCH_CTRL_STATS_EN
    ,
    output logic [31:0] taken_cnt,
    output logic [31:0] not_taken_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] imm_q, imm_d;
    logic        taken_q, taken_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic        illegal_q, illegal_d;

    logic        f3_legal;
    logic        signed_cmp;
    logic        br_taken;

    always_comb begin
        f3_legal = 1'b0;
        case (funct3)
            F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: f3_legal = 1'b1;
            default:                                          f3_legal = 1'b0;
        endcase
    end

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so one unsigned comparator serves both signed and unsigned branches.
    assign signed_cmp = (funct3_q == F3_BLT) || (funct3_q == F3_BGE);

    always_comb begin
        cmp_a = 32'd0;
        cmp_b = 32'd0;
        if (state_q == CMP) begin
            cmp_a = rs1_q ^ {signed_cmp, 31'd0};
            cmp_b = rs2_q ^ {signed_cmp, 31'd0};
        end
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3_q)
            F3_BEQ:           br_taken = cmp_eq;
            F3_BNE:           br_taken = ~cmp_eq;
            F3_BLT, F3_BLTU:  br_taken = cmp_lt;
            F3_BGE, F3_BGEU:  br_taken = ~cmp_lt;
            default:          br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        taken_d   = taken_q;
        next_pc_d = next_pc_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d = funct3;
                    rs1_d    = rs1_data;
                    rs2_d    = rs2_data;
                    pc_d     = pc;
                    imm_d    = imm;
                    if (f3_legal) begin
                        state_d = CMP;
                    end else begin
                        // Illegal encodings resolve immediately as a fall-through.
                        taken_d   = 1'b0;
                        illegal_d = 1'b1;
                        next_pc_d = pc + 32'd4;
                        state_d   = RESP;
                    end
                end
            end
            CMP: begin
                taken_d   = br_taken;
                illegal_d = 1'b0;
                next_pc_d = br_taken ? (pc_q + imm_q) : (pc_q + 32'd4);
                state_d   = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            funct3_q  <= 3'd0;
            rs1_q     <= 32'd0;
            rs2_q     <= 32'd0;
            pc_q      <= 32'd0;
            imm_q     <= 32'd0;
            taken_q   <= 1'b0;
            next_pc_q <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            taken_q   <= taken_d;
            next_pc_q <= next_pc_d;
            illegal_q <= illegal_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign taken      = taken_q;
    assign next_pc    = next_pc_q;
    assign illegal    = illegal_q;

`ifdef BRANCH_CTRL_STATS_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] not_taken_cnt_q, not_taken_cnt_d;
    logic        legal_hs;

    assign legal_hs = (state_q == RESP) && resp_ready && !illegal_q;

    always_comb begin
        taken_cnt_d     = taken_cnt_q;
        not_taken_cnt_d = not_taken_cnt_q;
        if (legal_hs) begin
            if (taken_q) taken_cnt_d     = taken_cnt_q + 32'd1;
            else         not_taken_cnt_d = not_taken_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q     <= 32'd0;
            not_taken_cnt_q <= 32'd0;
        end else begin
            taken_cnt_q     <= taken_cnt_d;
            not_taken_cnt_q <= not_taken_cnt_d;
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed, table-driven bench for branch_ctrl with an ideal comparator model
// and hand-written sequences for back-pressure and mid-flight reset.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, pc, imm;
    logic [31:0] cmp_a, cmp_b;
    logic        cmp_eq, cmp_lt;
    logic        resp_valid;
    logic        resp_ready;
    logic        taken;
    logic [31:0] next_pc;
    logic        illegal;
`ifdef BRANCH_CTRL_STATS_EN
    logic [31:0] taken_cnt, not_taken_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // The shared comparator sits outside the block; model it ideally.
    assign cmp_eq = (cmp_a == cmp_b);
    assign cmp_lt = (cmp_a < cmp_b);

    branch_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .taken(taken), .next_pc(next_pc), .illegal(illegal)
`ifdef BRANCH_CTRL_STATS_EN
        , .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b, pc, imm;
        logic        exp_taken;
        logic [31:0] exp_npc;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the block idle; returns at a negedge with it idle again.
    task automatic run_vec(input vec_t v);
        logic [31:0] exp_a, exp_b;
        exp_a = v.a;
        exp_b = v.b;
        if (v.f3 == 3'b100 || v.f3 == 3'b101) begin
            exp_a = v.a ^ 32'h8000_0000;
            exp_b = v.b ^ 32'h8000_0000;
        end
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; funct3 = v.f3; rs1_data = v.a; rs2_data = v.b;
        pc = v.pc; imm = v.imm; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h0BAD_F00D; pc = 32'h5555_5555; imm = 32'h1;
        if (!v.exp_ill) begin
            check("cmp_resp_valid", {31'd0, resp_valid}, 32'd0);
            check("cmp_a", cmp_a, exp_a);
            check("cmp_b", cmp_b, exp_b);
            @(negedge clk);
        end
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        check("taken", {31'd0, taken}, {31'd0, v.exp_taken});
        check("next_pc", next_pc, v.exp_npc);
        check("illegal", {31'd0, illegal}, {31'd0, v.exp_ill});
        check("resp_cmp_a", cmp_a | cmp_b, 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("after_hs_valid", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0100, 32'h0000_0020, 1'b1, 32'h0000_0120, 1'b0};
        vecs[1]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0200, 32'h0000_0040, 1'b1, 32'h0000_0240, 1'b0};
        vecs[2]  = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0200, 32'h0000_0040, 1'b0, 32'h0000_0204, 1'b0};
        vecs[3]  = '{3'b101, 32'h8000_0000, 32'h8000_0000, 32'h0000_0300, 32'hFFFF_FFF8, 1'b1, 32'h0000_02F8, 1'b0};
        vecs[4]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h0000_0300, 32'h0000_0010, 1'b0, 32'h0000_0304, 1'b0};
        vecs[5]  = '{3'b010, 32'h0000_0001, 32'h0000_0001, 32'h0000_0400, 32'h0000_0080, 1'b0, 32'h0000_0404, 1'b1};
        vecs[6]  = '{3'b011, 32'h0000_0005, 32'h0000_0009, 32'h0000_0500, 32'h0000_0080, 1'b0, 32'h0000_0504, 1'b1};
        vecs[7]  = '{3'b111, 32'h0000_0005, 32'h0000_0007, 32'h0000_0600, 32'h0000_0008, 1'b0, 32'h0000_0604, 1'b0};
        vecs[8]  = '{3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0700, 32'h0000_0100, 1'b1, 32'h0000_0800, 1'b0};
        vecs[9]  = '{3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0800, 32'h0000_0010, 1'b0, 32'h0000_0804, 1'b0};
        vecs[10] = '{3'b000, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[11] = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 32'h0000_0010, 1'b0};

        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; funct3 = 3'd0;
        rs1_data = 32'd0; rs2_data = 32'd0; pc = 32'd0; imm = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_taken", {31'd0, taken}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_next_pc", next_pc, 32'd0);
        check("rst_cmp", cmp_a | cmp_b, 32'd0);
`ifdef BRANCH_CTRL_STATS_EN
        check("rst_taken_cnt", taken_cnt, 32'd0);
        check("rst_not_taken_cnt", not_taken_cnt, 32'd0);
`endif

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

`ifdef BRANCH_CTRL_STATS_EN
        // Legal taken: vectors 0,1,3,8,11; legal not taken: 2,4,7,9,10.
        check("stat_taken_cnt", taken_cnt, 32'd5);
        check("stat_not_taken_cnt", not_taken_cnt, 32'd5);
`endif

        // Back-pressure: outcome held while new requests are presented and ignored.
        req_valid = 1'b1; funct3 = 3'b110; rs1_data = 32'd1; rs2_data = 32'd2;
        pc = 32'hFFFF_FFF0; imm = 32'h20;
        @(negedge clk);
        funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd4; pc = 32'h1000; imm = 32'h4;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            check("stall_taken", {31'd0, taken}, 32'd1);
            check("stall_next_pc", next_pc, 32'h0000_0010);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0; req_valid = 1'b0;
        check("hs_no_accept_ready", {31'd0, req_ready}, 32'd1);
        check("hs_no_accept_valid", {31'd0, resp_valid}, 32'd0);

        // Reset while in CMP.
        req_valid = 1'b1; funct3 = 3'b000; rs1_data = 32'h7; rs2_data = 32'h7;
        pc = 32'h900; imm = 32'h40;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstcmp_ready", {31'd0, req_ready}, 32'd1);
        check("rstcmp_valid", {31'd0, resp_valid}, 32'd0);
        check("rstcmp_next_pc", next_pc, 32'd0);
        check("rstcmp_cmp", cmp_a | cmp_b, 32'd0);
        resp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rstcmp_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        resp_ready = 1'b0;

        // Reset while in RESP.
        req_valid = 1'b1; funct3 = 3'b001; rs1_data = 32'h1; rs2_data = 32'h2;
        pc = 32'hA00; imm = 32'h40;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_resp_valid", {31'd0, resp_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstresp_valid", {31'd0, resp_valid}, 32'd0);
        check("rstresp_taken", {31'd0, taken}, 32'd0);
        check("rstresp_ready", {31'd0, req_ready}, 32'd1);
        resp_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rstresp_no_resp", {31'd0, resp_valid}, 32'd0);
        end
`ifdef BRANCH_CTRL_STATS_EN
        check("rst_cnt_taken", taken_cnt, 32'd0);
        check("rst_cnt_not_taken", not_taken_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
